// File: rtl/rs_cdb_multi.sv
// ALU reservation station: age-ordered select, NUM_CDB-port wakeup with same-edge dispatch
// bypass, registered valid/ready issue slot, mispredict flush and whole-block freeze (rdy).
module rs_cdb_multi #(
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32,
  parameter int NUM_CDB = 2,
  parameter int OP_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_vj,
  input  logic [XLEN-1:0]          in_vk,
  input  logic [TAG_W-1:0]         in_qj,
  input  logic [TAG_W-1:0]         in_qk,
  input  logic [OP_W-1:0]          in_opcode,
  input  logic [OP_W-1:0]          in_optype,
  input  logic [TAG_W-1:0]         in_dest,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_vj,
  output logic [XLEN-1:0]          out_vk,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_pc,
  output logic [OP_W-1:0]          out_opcode,
  output logic [OP_W-1:0]          out_optype,
  output logic [TAG_W-1:0]         out_dest,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } match_t;

  logic [DEPTH-1:0] busy;
  logic [TAG_W-1:0] qj     [DEPTH];
  logic [TAG_W-1:0] qk     [DEPTH];
  logic [XLEN-1:0]  vj     [DEPTH];
  logic [XLEN-1:0]  vk     [DEPTH];
  logic [XLEN-1:0]  pc     [DEPTH];
  logic [XLEN-1:0]  imm    [DEPTH];
  logic [OP_W-1:0]  opcode [DEPTH];
  logic [OP_W-1:0]  optype [DEPTH];
  logic [TAG_W-1:0] dest   [DEPTH];
  logic [DEPTH-1:0] older  [DEPTH];  // older[i][j]: entry i was dispatched before entry j

  match_t           wake_j [DEPTH];
  match_t           wake_k [DEPTH];
  match_t           byp_j;
  match_t           byp_k;
  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             any_ready;
  logic             active;
  logic             do_disp;
  logic             do_load;
  logic             do_drain;

  // Tag 0 means "value present" and never matches; scanning high-to-low lets the lowest port win.
  function automatic match_t cdb_match(input logic [TAG_W-1:0]         q,
                                       input logic [NUM_CDB-1:0]       v,
                                       input logic [NUM_CDB*TAG_W-1:0] tags,
                                       input logic [NUM_CDB*XLEN-1:0]  data);
    match_t m;
    m = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (v[k] && (q != '0) && (tags[k*TAG_W +: TAG_W] == q)) begin
        m.hit  = 1'b1;
        m.data = data[k*XLEN +: XLEN];
      end
    end
    return m;
  endfunction

  // NOTE: every always_comb output gets a default before any conditional logic, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    byp_j = cdb_match(in_qj, cdb_valid, cdb_tag, cdb_data);
    byp_k = cdb_match(in_qk, cdb_valid, cdb_tag, cdb_data);
    for (int i = 0; i < DEPTH; i++) begin
      wake_j[i] = cdb_match(qj[i], cdb_valid, cdb_tag, cdb_data);
      wake_k[i] = cdb_match(qk[i], cdb_valid, cdb_tag, cdb_data);
      ready[i]  = busy[i] && (qj[i] == '0) && (qk[i] == '0);
    end
  end

  // An entry wins when no other ready entry is older than it; the age matrix makes this unique.
  always_comb begin
    logic win;
    win     = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      win = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && ready[j] && older[j][i]) win = 1'b0;
      end
      if (win) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  assign in_ready  = ~&busy;
  assign any_ready = |ready;
  assign active    = rdy && !flush;
  assign do_disp   = active && in_valid && in_ready;
  assign do_load   = active && any_ready && (!out_valid || out_ready);
  assign do_drain  = active && !any_ready && out_valid && out_ready;

  // NOTE: operand/payload storage has no reset; busy qualifies every read, so only the
  // control state below needs clearing.
  always_ff @(posedge clk) begin
    if (active) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake_j[i].hit) vj[i] <= wake_j[i].data;
        if (wake_k[i].hit) vk[i] <= wake_k[i].data;
      end
      if (do_disp) begin
        vj[free_idx]     <= byp_j.hit ? byp_j.data : in_vj;
        vk[free_idx]     <= byp_k.hit ? byp_k.data : in_vk;
        pc[free_idx]     <= in_pc;
        imm[free_idx]    <= in_imm;
        opcode[free_idx] <= in_opcode;
        optype[free_idx] <= in_optype;
        dest[free_idx]   <= in_dest;
        // New entry is youngest: every other entry becomes older than it, it is older than none.
        for (int i = 0; i < DEPTH; i++) older[i][free_idx] <= 1'b1;
        older[free_idx] <= '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read in this block
  // sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      out_valid  <= 1'b0;
      occupancy  <= '0;
      out_vj     <= '0;
      out_vk     <= '0;
      out_imm    <= '0;
      out_pc     <= '0;
      out_opcode <= '0;
      out_optype <= '0;
      out_dest   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qj[i] <= '0;
        qk[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        busy      <= '0;
        out_valid <= 1'b0;
        occupancy <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wake_j[i].hit) qj[i] <= '0;
          if (wake_k[i].hit) qk[i] <= '0;
        end
        if (do_load) busy[sel_idx] <= 1'b0;
        if (do_disp) begin
          busy[free_idx] <= 1'b1;
          qj[free_idx]   <= byp_j.hit ? '0 : in_qj;
          qk[free_idx]   <= byp_k.hit ? '0 : in_qk;
        end
        case ({do_disp, do_load})
          2'b10:   occupancy <= occupancy + CNT_W'(1);
          2'b01:   occupancy <= occupancy - CNT_W'(1);
          default: occupancy <= occupancy;
        endcase
        if (do_load) begin
          out_valid  <= 1'b1;
          out_vj     <= vj[sel_idx];
          out_vk     <= vk[sel_idx];
          out_imm    <= imm[sel_idx];
          out_pc     <= pc[sel_idx];
          out_opcode <= opcode[sel_idx];
          out_optype <= optype[sel_idx];
          out_dest   <= dest[sel_idx];
        end else if (do_drain) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_cdb_multi.sv
// Scoreboard bench for rs_cdb_multi: directed dispatch/CDB vectors push expected issue payloads;
// a negedge monitor pops and compares on every completed issue handshake.
module tb_rs_cdb_multi;

  localparam int DEPTH   = 8;
  localparam int TAG_W   = 4;
  localparam int XLEN    = 32;
  localparam int NUM_CDB = 2;
  localparam int OP_W    = 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     rdy;
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [XLEN-1:0]          in_vj, in_vk, in_pc, in_imm;
  logic [TAG_W-1:0]         in_qj, in_qk, in_dest;
  logic [OP_W-1:0]          in_opcode, in_optype;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*XLEN-1:0]  cdb_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_vj, out_vk, out_imm, out_pc;
  logic [OP_W-1:0]          out_opcode, out_optype;
  logic [TAG_W-1:0]         out_dest;
  logic [CNT_W-1:0]         occupancy;

  typedef struct packed {
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [OP_W-1:0]  opcode;
    logic [OP_W-1:0]  optype;
    logic [TAG_W-1:0] dest;
  } item_t;

  item_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  rs_cdb_multi #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vj(in_vj), .in_vk(in_vk), .in_qj(in_qj), .in_qk(in_qk),
    .in_opcode(in_opcode), .in_optype(in_optype), .in_dest(in_dest),
    .in_pc(in_pc), .in_imm(in_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vj(out_vj), .out_vk(out_vk), .out_imm(out_imm), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_optype(out_optype), .out_dest(out_dest),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic item_t mk(input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk,
                               input logic [TAG_W-1:0] dest, input logic [OP_W-1:0] op,
                               input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
    item_t it;
    it.vj = vj; it.vk = vk; it.imm = imm; it.pc = pc;
    it.opcode = op; it.optype = ~op; it.dest = dest;
    return it;
  endfunction

  // Monitor: one comparison per completed issue handshake.
  always @(negedge clk) begin : monitor
    item_t act;
    item_t exp;
    if (rst && rdy && !flush && out_valid && out_ready) begin
      act.vj = out_vj; act.vk = out_vk; act.imm = out_imm; act.pc = out_pc;
      act.opcode = out_opcode; act.optype = out_optype; act.dest = out_dest;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: got dest 0x%0h vj 0x%0h, expected no issue", out_dest, out_vj);
      end else begin
        exp = exp_q.pop_front();
        check("issue_payload", act, exp);
      end
    end
  end

  // Two ports must never broadcast the same live tag in one cycle.
  always @(negedge clk) begin
    if (cdb_valid[0] && cdb_valid[1] && (cdb_tag[TAG_W-1:0] != '0))
      assert (cdb_tag[TAG_W-1:0] != cdb_tag[2*TAG_W-1:TAG_W])
        else $error("duplicate CDB tag 0x%0h in one cycle", cdb_tag[TAG_W-1:0]);
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0;
    in_vj = '0; in_vk = '0; in_qj = '0; in_qk = '0;
    in_opcode = '0; in_optype = '0; in_dest = '0; in_pc = '0; in_imm = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic set_disp(input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk,
                          input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                          input logic [TAG_W-1:0] dest, input logic [OP_W-1:0] op,
                          input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
    in_valid = 1'b1;
    in_vj = vj; in_vk = vk; in_qj = qj; in_qk = qk;
    in_dest = dest; in_opcode = op; in_optype = ~op; in_pc = pc; in_imm = imm;
  endtask

  task automatic set_cdb(input int port, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
    cdb_valid[port]                = 1'b1;
    cdb_tag[port*TAG_W +: TAG_W]   = tag;
    cdb_data[port*XLEN +: XLEN]    = data;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    check({name, "_queue_empty"}, 160'(exp_q.size()), 160'd0);
    check({name, "_out_valid_low"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; out_ready = 1'b0;
    idle();
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_vj", out_vj, 0);
    check("reset_out_dest", out_dest, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: asynchronous reset with five busy entries plus the issue slot loaded
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_disp(32'h10 + 32'(i), 32'h20, '0, '0, TAG_W'(i + 1), OP_W'(i), 32'h40, 32'h0);
      tick();
    end
    idle();
    @(negedge clk);
    check("t1_occ_before_reset", occupancy, 5);
    check("t1_out_valid_before_reset", out_valid, 1);
    #1 rst = 1'b0;
    #1;
    check("t1_async_out_valid", out_valid, 0);
    check("t1_async_occupancy", occupancy, 0);
    check("t1_async_in_ready", in_ready, 1);
    tick();
    rst = 1'b1;
    tick();

    // 2: A waits on tag 3; B and C are ready; wakeup of A later -> issue B, C, A
    out_ready = 1'b1;
    set_disp(32'hA0, 32'hA1, 4'd3, 4'd0, 4'hA, 4'd1, 32'h200, 32'h20);
    tick();
    set_disp(32'hB0, 32'hB1, 4'd0, 4'd0, 4'hB, 4'd2, 32'h204, 32'h21);
    exp_q.push_back(mk(32'hB0, 32'hB1, 4'hB, 4'd2, 32'h204, 32'h21));
    tick();
    set_disp(32'hC0, 32'hC1, 4'd0, 4'd0, 4'hC, 4'd3, 32'h208, 32'h22);
    exp_q.push_back(mk(32'hC0, 32'hC1, 4'hC, 4'd3, 32'h208, 32'h22));
    tick();
    idle();
    tick();
    tick();
    set_cdb(0, 4'd3, 32'h55);
    exp_q.push_back(mk(32'h55, 32'hA1, 4'hA, 4'd1, 32'h200, 32'h20));
    tick();
    idle();
    wait_drain("t2");

    // 3: same-edge bypass from both CDB ports
    set_disp(32'hDEAD0001, 32'hDEAD0002, 4'd5, 4'd6, 4'h3, 4'd3, 32'h300, 32'h30);
    set_cdb(0, 4'd5, 32'h11);
    set_cdb(1, 4'd6, 32'h22);
    exp_q.push_back(mk(32'h11, 32'h22, 4'h3, 4'd3, 32'h300, 32'h30));
    tick();
    idle();
    @(negedge clk);
    check("t3_not_issued_yet", out_valid, 0);
    check("t3_occupancy", occupancy, 1);
    @(negedge clk);
    check("t3_out_valid", out_valid, 1);
    check("t3_out_vj", out_vj, 32'h11);
    check("t3_out_vk", out_vk, 32'h22);
    wait_drain("t3");

    // 4: back-pressure, fill to DEPTH plus the issue slot, then drain in age order
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      set_disp(32'h100 + 32'(i), 32'h200 + 32'(i), '0, '0, TAG_W'(i + 1), OP_W'(i),
               32'h1000 + 32'(4 * i), 32'(i));
      exp_q.push_back(mk(32'h100 + 32'(i), 32'h200 + 32'(i), TAG_W'(i + 1), OP_W'(i),
                         32'h1000 + 32'(4 * i), 32'(i)));
      tick();
    end
    idle();
    @(negedge clk);
    check("t4_full_occupancy", occupancy, DEPTH);
    check("t4_full_in_ready", in_ready, 0);
    check("t4_slot_valid", out_valid, 1);
    check("t4_slot_vj", out_vj, 32'h100);
    tick();
    set_disp(32'hDEAD, 32'hBEEF, '0, '0, 4'hF, 4'hF, 32'hFFF0, 32'hFF);
    tick();
    idle();
    @(negedge clk);
    check("t4_ignored_occupancy", occupancy, DEPTH);
    check("t4_ignored_in_ready", in_ready, 0);
    repeat (3) tick();
    @(negedge clk);
    check("t4_stable_pc", out_pc, 32'h1000);
    check("t4_stable_dest", out_dest, 1);
    tick();
    out_ready = 1'b1;
    wait_drain("t4");
    check("t4_drained_occupancy", occupancy, 0);
    check("t4_drained_in_ready", in_ready, 1);

    // 5: flush in the same cycle as a dispatch and a CDB hit
    out_ready = 1'b0;
    set_disp(32'h501, 32'h502, 4'd0, 4'd0, 4'h1, 4'd5, 32'h500, 32'h50);
    tick();
    set_disp(32'h511, 32'h512, 4'd7, 4'd0, 4'h2, 4'd5, 32'h504, 32'h51);
    tick();
    idle();
    @(negedge clk);
    check("t5_pre_out_valid", out_valid, 1);
    check("t5_pre_occupancy", occupancy, 1);
    tick();
    flush = 1'b1;
    set_disp(32'h521, 32'h522, 4'd0, 4'd0, 4'h3, 4'd5, 32'h508, 32'h52);
    set_cdb(0, 4'd7, 32'h77);
    tick();
    idle();
    @(negedge clk);
    check("t5_flush_occupancy", occupancy, 0);
    check("t5_flush_out_valid", out_valid, 0);
    check("t5_flush_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b1;
    set_cdb(0, 4'd7, 32'h78);
    tick();
    idle();
    repeat (4) tick();
    @(negedge clk);
    check("t5_nothing_issued", out_valid, 0);
    check("t5_still_empty", occupancy, 0);
    tick();

    // 6: freeze ignores CDB and dispatch; the frozen broadcast is lost
    set_disp(32'h0, 32'h66, 4'd9, 4'd0, 4'h9, 4'd6, 32'h600, 32'h60);
    tick();
    idle();
    rdy = 1'b0;
    set_cdb(0, 4'd9, 32'h99);
    set_disp(32'h611, 32'h612, 4'd0, 4'd0, 4'h4, 4'd7, 32'h604, 32'h61);
    repeat (3) tick();
    idle();
    rdy = 1'b1;
    @(negedge clk);
    check("t6_freeze_occupancy", occupancy, 1);
    check("t6_freeze_out_valid", out_valid, 0);
    repeat (4) tick();
    @(negedge clk);
    check("t6_not_woken", out_valid, 0);
    check("t6_still_waiting", occupancy, 1);
    tick();
    set_cdb(1, 4'd9, 32'h77);
    exp_q.push_back(mk(32'h77, 32'h66, 4'h9, 4'd6, 32'h600, 32'h60));
    tick();
    idle();
    wait_drain("t6");
    check("t6_final_occupancy", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
